// File: rtl/mod_mult_seq.sv
// Sequential interleaved modular multiplier: result = (a * b) mod p, one bit of a per cycle.
// Optional MODMUL_EARLY_EXIT_EN starts at the most significant 1 of a, shortening latency.
module mod_mult_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] result_o,
  output logic         rdy_o,
  output logic         err_o
);

  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFail} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, p_q, p_d;
  logic [W-1:0]    r_q, r_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] init_idx;
  logic [W+1:0]    t, two_p, p_ext;
  logic [W-1:0]    step;

`ifdef MODMUL_EARLY_EXIT_EN
  // a == 0 yields index 0: a single step with a zero bit produces r = 0.
  always_comb begin
    init_idx = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (a_i[i]) init_idx = IdxW'(i);
    end
  end
`else
  assign init_idx = IdxW'(W - 1);
`endif

  // r < p and b < p keep t below 3p, so one conditional subtraction of 2p or p suffices.
  always_comb begin
    t     = {1'b0, r_q, 1'b0} + (a_q[idx_q] ? {2'b00, b_q} : '0);
    two_p = {1'b0, p_q, 1'b0};
    p_ext = {2'b00, p_q};
    if (t >= two_p) begin
      step = W'(t - two_p);
    end else if (t >= p_ext) begin
      step = W'(t - p_ext);
    end else begin
      step = W'(t);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    r_d      = r_q;
    idx_d    = idx_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d = a_i;
          b_d = b_i;
          p_d = p_i;
          if ((p_i == '0) || (b_i >= p_i)) begin
            state_d = StFail;
          end else begin
            state_d = StRun;
            r_d     = '0;
            idx_d   = init_idx;
          end
        end
      end
      StRun: begin
        r_d = step;
        if (idx_q == '0) begin
          result_d = step;
          err_d    = 1'b0;
          state_d  = StIdle;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StFail: begin
        result_d = '0;
        err_d    = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign rdy_o    = (state_q == StIdle);
  assign result_o = result_q;
  assign err_o    = err_q;

endmodule

// File: doc/mod_mult_seq.md
Name: mod_mult_seq

Overview:
- Sequential interleaved modular multiplier. Computes result = (a * b) mod p, using one bit of a per cycle.
- Sits directly downstream of the binary extended-Euclid inverse unit. Its 32-bit inverse output drives b, so the pair performs modular division a / k mod p.
- Uses the same start/rdy handshake as the inverse unit, so the two chain without glue logic.

Parameters:
- W, 32, operand/modulus width. The datapath is sized W+2 bits internally.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request. Sampled on a rising edge only while rdy=1.
- a  input  W  multiplicand, unsigned, any value (need not be reduced)
- b  input  W  multiplier, unsigned, must satisfy b < p. Normally the inverse unit's output.
- p  input  W  modulus, unsigned, must be nonzero
- result  output  W  (a*b) mod p. Held stable until the next accepted start.
- rdy  output  1  1 = idle and result valid; 0 = busy
- err  output  1  1 = last accepted operation had an illegal operand (p==0 or b>=p)

Behaviour:
- Reset: state=IDLE, rdy=1, result=0, err=0; internal accumulator and counter cleared. Reset asserted mid-operation aborts immediately; the next rising edge after deassertion is in IDLE.
- States:
  - IDLE: rdy=1.
  - RUN: rdy=0.
  - FAIL: rdy=0, one cycle.
- IDLE, start=1 at edge N:
  - a, b and p are latched.
  - If p==0 or b>=p: go to FAIL.
  - Otherwise: go to RUN with r=0 and idx=W-1.
- FAIL: at edge N+1, result<=0, err<=1, go to IDLE.
- RUN, one step per cycle:
  - t = 2r + (a_lat[idx] ? b_lat : 0), computed W+2 bits wide.
  - r_next = t-2p if t>=2p; else t-p if t>=p; else t.
  - Invariant: r < p throughout.
  - If idx==0: result<=r_next[W-1:0], err<=0, go to IDLE. Otherwise idx<=idx-1.
- Latency (feature disabled): rdy low for exactly W cycles after the accepting edge. An operation accepted at edge N has rdy=1 and a valid result at edge N+W.
- start while rdy=0 is ignored. It does not restart, queue or corrupt the operation.
- Inputs a, b and p may change freely after the accepting edge; only the latched copies are used.
- Back-to-back: start=1 held high re-accepts on the same edge rdy rises. The new operation uses the inputs present on that edge, and result changes only at its completion.
- result and err change only on a completion edge (RUN with idx==0, or FAIL) or on reset.
- Comparisons are unsigned. 2p is formed W+1 bits wide and never wraps.

Optional Feature:
- MODMUL_EARLY_EXIT_EN
- Defined:
  - On acceptance, idx is initialised to the position of the most significant 1 in a.
  - If a==0 (and operands are legal), the block completes at edge N+1 with result=0, err=0.
  - Latency is msb(a)+1 cycles, 1..W.
  - Operand checking is unchanged and takes priority over the a==0 shortcut.
- Undefined: fixed latency W for every legal operation. No priority encoder is synthesised.

Test Plan:
- Basic: a=3, b=5, p=7 (5 = inverse of 3 mod 7) → result=1, err=0. rdy low exactly 32 cycles, high at edge N+32.
- Near-full width: a=0xFFFFFFFF, b=0xFFFFFFFA, p=0xFFFFFFFB → result=0xFFFFFFF7, err=0. Also a=0xFFFFFFFF, b=1, p=0xFFFFFFFB → result=4.
- Illegal operands:
  - a=5, b=9, p=7 → err=1, result=0, rdy back high after 1 cycle.
  - p=0 → err=1.
  - A following legal op a=2, b=3, p=7 → result=6, err=0.
- Busy start: start a=3, b=5, p=7, then pulse start with a=6, b=6, p=7 at cycle 10 → ignored. Result=1 at N+32, and no second operation begins.
- Reset mid-op:
  - Assert reset at cycle 15 of a=3, b=5, p=7 → rdy=1, result=0, err=0 immediately.
  - Restart a=4, b=2, p=7 → result=1 after 32 cycles.
- With MODMUL_EARLY_EXIT_EN:
  - a=0, b=3, p=7 → result=0 after 1 cycle.
  - a=3, b=5, p=7 → result=1 after 2 cycles.
  - a=0x80000000, b=1, p=0xFFFFFFFB → result=0x80000000 after 32 cycles.
